// File: rtl/imem_controller_pkg.sv
// Shared widths and state encodings for the instruction-memory controller.
// Width macros default here unless a project-wide header has already set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IMEMORY_SIZE
`define IMEMORY_SIZE 256
`endif

package imem_controller_pkg;

  typedef enum logic [1:0] {
    IMC_BOOT = 2'd0,
    IMC_LOAD = 2'd1,
    IMC_RUN  = 2'd2
  } imc_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/imem_arbiter.sv
// Run-mode fetch/debug arbitration for the single memory port; fetch grant is same-cycle,
// debug data and ack are registered one cycle later, and fetch wins unless debug has starved.
module imem_arbiter
  import imem_controller_pkg::*;
#(
  parameter int INST_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_run,
  input  logic                  i_fetch_req,
  input  logic                  i_dbg_req,
  input  logic [INST_WIDTH-1:0] i_mem_rdata,
  output logic                  o_fetch_gnt,
  output logic                  o_dbg_win,
  output logic                  o_dbg_ack,
  output logic [INST_WIDTH-1:0] o_dbg_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  r_inflight;
  logic [INST_WIDTH-1:0] r_dbg_rdata;
  logic                  w_dbg_open;
  logic                  w_dbg_win;
  logic                  w_fetch_gnt;

  // The ack cycle blocks a re-grant so the host has time to drop dbg_req.
  assign w_dbg_open  = i_run && i_dbg_req && !r_inflight;
  assign w_dbg_win   = w_dbg_open && (!i_fetch_req || (r_starve_cnt == LIMIT));
  assign w_fetch_gnt = i_run && i_fetch_req && !w_dbg_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_inflight   <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_inflight <= w_dbg_win;
      if (w_dbg_win) begin
        r_dbg_rdata  <= i_mem_rdata;
        r_starve_cnt <= '0;
      end else if (w_fetch_gnt && w_dbg_open && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign o_fetch_gnt = w_fetch_gnt;
  assign o_dbg_win   = w_dbg_win;
  assign o_dbg_ack   = r_inflight;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: rtl/imem_controller.sv
// Owns the instruction-memory port: streams a program image in (BOOT/LOAD), then arbitrates fetch vs debug (RUN).
// Load beats write in the accept cycle; load_ready is level-based on state, fetch is same-cycle, debug acks next cycle.
module imem_controller
  import imem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int INST_WIDTH   = `INST_WIDTH,
  parameter int IMEMORY_SIZE = `IMEMORY_SIZE,
  parameter int STARVE_LIMIT = 4,
  parameter int BOOT_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_gnt,
  output logic [INST_WIDTH-1:0] fetch_instr,
  output logic                  cpu_hold,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [INST_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [INST_WIDTH-1:0] mem_rdata
);

  localparam imc_state_t            RESET_STATE = (BOOT_HOLD != 0) ? IMC_BOOT : IMC_RUN;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST    = ADDR_WIDTH'(IMEMORY_SIZE - 1);

  imc_state_t            r_state;
  imc_state_t            w_next_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_load_done;
  logic                  r_load_err;
  logic                  w_in_load;
  logic                  w_run;
  logic                  w_beat;
  logic                  w_start_ok;
  logic                  w_fetch_gnt;
  logic                  w_dbg_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IMC_BOOT: if (load_start) w_next_state = IMC_LOAD;
      IMC_LOAD: if (w_beat && load_last) w_next_state = IMC_RUN;
      IMC_RUN:  if (load_start) w_next_state = IMC_LOAD;
      default:  w_next_state = IMC_BOOT;
    endcase
  end

  always_comb begin
    w_in_load   = (r_state == IMC_LOAD);
    w_run       = (r_state == IMC_RUN);
    w_start_ok  = load_start && (r_state == IMC_BOOT || r_state == IMC_RUN);
    w_beat      = w_in_load && load_valid;
    cpu_hold    = !w_run;
    load_busy   = w_in_load;
    load_ready  = w_in_load;
    mem_we      = w_beat;
    mem_wdata   = w_beat ? load_data : '0;
    fetch_gnt   = w_fetch_gnt;
    fetch_instr = w_fetch_gnt ? mem_rdata : '0;
    if (w_in_load) begin
      mem_addr = r_ptr;
    end else if (w_dbg_win) begin
      mem_addr = dbg_addr;
    end else if (w_fetch_gnt) begin
      mem_addr = fetch_pc;
    end else begin
      mem_addr = '0;
    end
  end

  // Pointer wraps at the last physical word, not at the address-width boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_load_err  <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= w_beat && load_last;
      if (w_start_ok) begin
        r_ptr      <= load_base;
        r_load_err <= 1'b0;
      end else if (w_beat) begin
        if (r_ptr == PTR_LAST) begin
          r_ptr      <= '0;
          r_load_err <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign load_done = r_load_done;
  assign load_err  = r_load_err;

  imem_arbiter #(
    .INST_WIDTH   (INST_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arbiter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (w_run),
    .i_fetch_req (fetch_req),
    .i_dbg_req   (dbg_req),
    .i_mem_rdata (mem_rdata),
    .o_fetch_gnt (w_fetch_gnt),
    .o_dbg_win   (w_dbg_win),
    .o_dbg_ack   (dbg_ack),
    .o_dbg_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_imem_controller.sv
// Directed vector bench for imem_controller with a behavioural single-port memory.
module tb_imem_controller;

  localparam int AW   = 8;
  localparam int IW   = 32;
  localparam int SIZE = 256;

  localparam logic [IW-1:0] D1 = 32'hC0DE0001;
  localparam logic [IW-1:0] D2 = 32'hC0DE0002;
  localparam logic [IW-1:0] D3 = 32'hC0DE0003;
  localparam logic [IW-1:0] D4 = 32'hC0DE0004;
  localparam logic [IW-1:0] D5 = 32'hC0DE0005;
  localparam logic [IW-1:0] D6 = 32'hC0DE0006;
  localparam logic [IW-1:0] D7 = 32'hC0DE0007;
  localparam logic [IW-1:0] D8 = 32'hC0DE0008;
  localparam logic [IW-1:0] D9 = 32'hC0DE0009;
  localparam logic [IW-1:0] M0 = 32'hA5000000;
  localparam int NV = 29;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_start, load_valid, load_last;
  logic [AW-1:0] load_base;
  logic [IW-1:0] load_data;
  logic          load_ready, load_busy, load_done, load_err;
  logic          fetch_req, fetch_gnt, cpu_hold;
  logic [AW-1:0] fetch_pc;
  logic [IW-1:0] fetch_instr;
  logic          dbg_req, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [IW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  logic [IW-1:0] mem [SIZE];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done_seen = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  always @(negedge clk) if (mon_en && load_done) n_done_seen++;

  imem_controller #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .IMEMORY_SIZE(SIZE), .STARVE_LIMIT(4), .BOOT_HOLD(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
    .fetch_instr(fetch_instr), .cpu_hold(cpu_hold),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic ls; logic [AW-1:0] lb; logic lv; logic [IW-1:0] ld; logic ll;
    logic fr; logic [AW-1:0] fpc; logic dr; logic [AW-1:0] da;
    logic hold; logic busy; logic done; logic err; logic we; logic [AW-1:0] maddr;
    logic fgnt; logic [IW-1:0] finstr; logic ack; logic [IW-1:0] drd;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(
    input logic ls, input logic [AW-1:0] lb, input logic lv, input logic [IW-1:0] ld, input logic ll,
    input logic fr, input logic [AW-1:0] fpc, input logic dr, input logic [AW-1:0] da,
    input logic hold, input logic busy, input logic done, input logic err, input logic we,
    input logic [AW-1:0] maddr, input logic fgnt, input logic [IW-1:0] finstr,
    input logic ack, input logic [IW-1:0] drd);
    vec_t v;
    v.ls = ls; v.lb = lb; v.lv = lv; v.ld = ld; v.ll = ll;
    v.fr = fr; v.fpc = fpc; v.dr = dr; v.da = da;
    v.hold = hold; v.busy = busy; v.done = done; v.err = err; v.we = we;
    v.maddr = maddr; v.fgnt = fgnt; v.finstr = finstr; v.ack = ack; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    load_start = v.ls; load_base = v.lb; load_valid = v.lv; load_data = v.ld; load_last = v.ll;
    fetch_req = v.fr; fetch_pc = v.fpc; dbg_req = v.dr; dbg_addr = v.da;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = M0 | IW'(i);

    //              ls lb     lv ld  ll fr fpc    dr da     hold busy done err we maddr fgnt finstr ack drd
    vt[0]  = mk(1, 'h10, 0, 0,  0, 1, 'h11, 0, 'h00,  1, 0, 0, 0, 0, 'h00, 0, 0,  0, 0);
    vt[1]  = mk(0, 'h00, 1, D1, 0, 1, 'h11, 0, 'h00,  1, 1, 0, 0, 1, 'h10, 0, 0,  0, 0);
    vt[2]  = mk(1, 'h40, 1, D2, 0, 1, 'h11, 0, 'h00,  1, 1, 0, 0, 1, 'h11, 0, 0,  0, 0);
    vt[3]  = mk(0, 'h00, 0, 0,  0, 1, 'h11, 0, 'h00,  1, 1, 0, 0, 0, 'h12, 0, 0,  0, 0);
    vt[4]  = mk(0, 'h00, 1, D3, 1, 1, 'h11, 0, 'h00,  1, 1, 0, 0, 1, 'h12, 0, 0,  0, 0);
    vt[5]  = mk(0, 'h00, 0, 0,  0, 1, 'h11, 0, 'h00,  0, 0, 1, 0, 0, 'h11, 1, D2, 0, 0);
    vt[6]  = mk(0, 'h00, 0, 0,  0, 1, 'h10, 0, 'h00,  0, 0, 0, 0, 0, 'h10, 1, D1, 0, 0);
    for (int i = 7; i <= 10; i++)
      vt[i] = mk(0, 'h00, 0, 0,  0, 1, 'h00, 1, 'h12,  0, 0, 0, 0, 0, 'h00, 1, M0, 0, 0);
    vt[11] = mk(0, 'h00, 0, 0,  0, 1, 'h00, 1, 'h12,  0, 0, 0, 0, 0, 'h12, 0, 0,  0, 0);
    vt[12] = mk(0, 'h00, 0, 0,  0, 1, 'h00, 1, 'h12,  0, 0, 0, 0, 0, 'h00, 1, M0, 1, D3);
    vt[13] = mk(0, 'h00, 0, 0,  0, 1, 'h00, 0, 'h00,  0, 0, 0, 0, 0, 'h00, 1, M0, 0, D3);
    vt[14] = mk(0, 'h00, 0, 0,  0, 0, 'h00, 1, 'h10,  0, 0, 0, 0, 0, 'h10, 0, 0,  0, D3);
    vt[15] = mk(0, 'h00, 0, 0,  0, 0, 'h00, 1, 'h10,  0, 0, 0, 0, 0, 'h00, 0, 0,  1, D1);
    vt[16] = mk(0, 'h00, 0, 0,  0, 0, 'h00, 0, 'h00,  0, 0, 0, 0, 0, 'h00, 0, 0,  0, D1);
    vt[17] = mk(1, 'h20, 0, 0,  0, 1, 'h10, 0, 'h00,  0, 0, 0, 0, 0, 'h10, 1, D1, 0, D1);
    vt[18] = mk(0, 'h00, 1, D4, 1, 1, 'h10, 0, 'h00,  1, 1, 0, 0, 1, 'h20, 0, 0,  0, D1);
    vt[19] = mk(1, 'h30, 0, 0,  0, 0, 'h00, 1, 'h20,  0, 0, 1, 0, 0, 'h20, 0, 0,  0, D1);
    vt[20] = mk(0, 'h00, 1, D5, 1, 0, 'h00, 0, 'h00,  1, 1, 0, 0, 1, 'h30, 0, 0,  1, D4);
    vt[21] = mk(0, 'h00, 0, 0,  0, 1, 'h30, 0, 'h00,  0, 0, 1, 0, 0, 'h30, 1, D5, 0, D4);
    vt[22] = mk(1, 'hFF, 0, 0,  0, 0, 'h00, 0, 'h00,  0, 0, 0, 0, 0, 'h00, 0, 0,  0, D4);
    vt[23] = mk(0, 'h00, 1, D6, 0, 0, 'h00, 0, 'h00,  1, 1, 0, 0, 1, 'hFF, 0, 0,  0, D4);
    vt[24] = mk(0, 'h00, 1, D7, 1, 0, 'h00, 0, 'h00,  1, 1, 0, 1, 1, 'h00, 0, 0,  0, D4);
    vt[25] = mk(0, 'h00, 0, 0,  0, 1, 'h00, 0, 'h00,  0, 0, 1, 1, 0, 'h00, 1, D7, 0, D4);
    vt[26] = mk(0, 'h00, 0, 0,  0, 1, 'hFF, 0, 'h00,  0, 0, 0, 1, 0, 'hFF, 1, D6, 0, D4);
    vt[27] = mk(1, 'h50, 0, 0,  0, 0, 'h00, 0, 'h00,  0, 0, 0, 1, 0, 'h00, 0, 0,  0, D4);
    vt[28] = mk(0, 'h00, 0, 0,  0, 0, 'h00, 0, 'h00,  1, 1, 0, 0, 0, 'h50, 0, 0,  0, D4);

    reset_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 1, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst_cpu_hold", 0, IW'(cpu_hold), 1);
    chk("rst_fetch_gnt", 0, IW'(fetch_gnt), 0);
    chk("rst_load_done", 0, IW'(load_done), 0);
    chk("rst_load_err", 0, IW'(load_err), 0);
    chk("rst_dbg_ack", 0, IW'(dbg_ack), 0);
    chk("rst_dbg_rdata", 0, dbg_rdata, 0);
    chk("rst_load_busy", 0, IW'(load_busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      @(negedge clk);
      chk("cpu_hold",    i, IW'(cpu_hold),   IW'(vt[i].hold));
      chk("load_busy",   i, IW'(load_busy),  IW'(vt[i].busy));
      chk("load_ready",  i, IW'(load_ready), IW'(vt[i].busy));
      chk("load_done",   i, IW'(load_done),  IW'(vt[i].done));
      chk("load_err",    i, IW'(load_err),   IW'(vt[i].err));
      chk("mem_we",      i, IW'(mem_we),     IW'(vt[i].we));
      chk("mem_addr",    i, IW'(mem_addr),   IW'(vt[i].maddr));
      chk("fetch_gnt",   i, IW'(fetch_gnt),  IW'(vt[i].fgnt));
      chk("fetch_instr", i, fetch_instr,     vt[i].finstr);
      chk("dbg_ack",     i, IW'(dbg_ack),    IW'(vt[i].ack));
      chk("dbg_rdata",   i, dbg_rdata,       vt[i].drd);
      if (vt[i].we) chk("mem_wdata", i, mem_wdata, vt[i].ld);
      @(posedge clk); #1;
    end

    chk("img_0x10", 0, mem[8'h10], D1);
    chk("img_0x11", 0, mem[8'h11], D2);
    chk("img_0x12", 0, mem[8'h12], D3);
    chk("img_0xFF", 0, mem[8'hFF], D6);
    chk("img_0x00", 0, mem[8'h00], D7);

    // Reset mid-load: one beat lands, then reset arrives between edges.
    drive(mk(0, 0, 1, D8, 0, 1, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    load_data = D9;
    #3;
    reset_n = 1'b0;
    mon_en  = 1'b1;
    #1;
    chk("mid_cpu_hold", 1, IW'(cpu_hold), 1);
    chk("mid_load_busy", 1, IW'(load_busy), 0);
    chk("mid_load_ready", 1, IW'(load_ready), 0);
    chk("mid_load_done", 1, IW'(load_done), 0);
    chk("mid_load_err", 1, IW'(load_err), 0);
    chk("mid_dbg_ack", 1, IW'(dbg_ack), 0);
    chk("mid_dbg_rdata", 1, dbg_rdata, 0);
    chk("mid_mem_we", 1, IW'(mem_we), 0);
    chk("mid_fetch_gnt", 1, IW'(fetch_gnt), 0);
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1;
    load_last = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_cpu_hold", 2, IW'(cpu_hold), 1);
    chk("post_fetch_gnt", 2, IW'(fetch_gnt), 0);
    chk("post_load_ready", 2, IW'(load_ready), 0);
    chk("post_done_pulses", 2, IW'(n_done_seen), 0);
    chk("partial_0x50", 2, mem[8'h50], D8);
    chk("untouched_0x51", 2, mem[8'h51], M0 | 32'h51);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
